// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program counter.
package pc_pkg;
    localparam logic [31:0] PC_INCR = 32'd4;
    typedef enum logic [1:0] {S_RESET, S_FETCH, S_TRAP} pc_state_t;
    typedef enum logic [1:0] {SEL_JUMP, SEL_BRANCH, SEL_PEND, SEL_SEQ} pc_sel_t;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-pc priority mux (jump > branch > pending > sequential) with alignment check.
module pc_next_sel
    import pc_pkg::*;
(
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    input  logic [31:0] pc_plus4,
    output logic [31:0] target,
    output logic        misaligned
);
    pc_sel_t sel;
    always_comb begin
        sel = jump_en ? SEL_JUMP : branch_taken ? SEL_BRANCH : pend_valid ? SEL_PEND : SEL_SEQ;
        target = sel == SEL_JUMP ? jump_target :
                 sel == SEL_BRANCH ? branch_target :
                 sel == SEL_PEND ? pend_target : pc_plus4;
        misaligned = |target[1:0];
    end
endmodule

// File: rtl/program_counter.sv
// program_counter: fetch PC with a one-entry pending-redirect latch.
// Define PROGRAM_COUNTER_TRAP_EN to redirect misaligned targets to TRAP_VECTOR.
module program_counter
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        misalign_trap
);
    pc_state_t   state, state_nxt;
    logic [31:0] pc_nxt, pend_target, pend_target_nxt, sel_target, load;
    logic        pend_valid, pend_valid_nxt, misaligned, advance, redirect, trap_hit;

    pc_next_sel u_next_sel (
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pend_valid    (pend_valid),
        .pend_target   (pend_target),
        .pc_plus4      (pc_plus4),
        .target        (sel_target),
        .misaligned    (misaligned)
    );

    assign pc_plus4    = pc + PC_INCR;
    assign fetch_valid = state == S_FETCH;
    assign advance     = fetch_valid && imem_ready && !stall;
    assign redirect    = jump_en || branch_taken;

`ifdef PROGRAM_COUNTER_TRAP_EN
    assign trap_hit      = advance && misaligned;
    assign load          = sel_target;
    assign misalign_trap = state == S_TRAP;
`else
    assign trap_hit      = 1'b0;
    assign load          = misaligned ? {sel_target[31:2], 2'b00} : sel_target;
    assign misalign_trap = 1'b0;
`endif

    // Reset and trap both last one cycle; a held fetch latches the newest redirect.
    always_comb begin
        state_nxt       = trap_hit ? S_TRAP : S_FETCH;
        pc_nxt          = trap_hit ? TRAP_VECTOR : advance ? load : pc;
        pend_valid_nxt  = (advance || state == S_TRAP) ? 1'b0 : pend_valid || redirect;
        pend_target_nxt = (!advance && state != S_TRAP && redirect) ?
                          (jump_en ? jump_target : branch_target) : pend_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RESET;
            pc          <= RESET_VECTOR;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
        end
    end
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed plus randomized checks against a behavioural PC model.
module tb_program_counter;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
`ifdef PROGRAM_COUNTER_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, branch_taken = 1'b0, jump_en = 1'b0;
    logic        imem_ready = 1'b1, fetch_valid, misalign_trap;
    logic [31:0] branch_target = '0, jump_target = '0, pc, pc_plus4;

    int total = 0, bad = 0;
    int m_mode = 0;  // 0 reset, 1 fetching, 2 trap
    logic [31:0] m_pc = RV;
    logic [31:0] pend_q[$];

    program_counter #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump_en(jump_en), .jump_target(jump_target),
        .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt,
                         input logic ir, input logic st);
        jump_en = j; jump_target = jt; branch_taken = b; branch_target = bt;
        imem_ready = ir; stall = st;
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = RV; pend_q.delete();
    endtask

    task automatic compare_model();
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_mode == 1});
        check("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_mode == 2});
    endtask

    // Advance the model by one rising edge using the inputs held across it, then compare.
    task automatic tick();
        logic [31:0] tgt;
        @(posedge clk);
        if (rst) model_reset();
        else if (m_mode == 2) begin
            m_mode = 1;
            pend_q.delete();
        end else if (m_mode == 1 && imem_ready && !stall) begin
            tgt = jump_en ? jump_target : branch_taken ? branch_target :
                  pend_q.size() != 0 ? pend_q[0] : m_pc + 32'd4;
            pend_q.delete();
            if (TRAP_EN && tgt % 4 != 0) begin
                m_mode = 2;
                m_pc = TV;
            end else m_pc = tgt - tgt % 4;
        end else begin
            if (m_mode == 0) m_mode = 1;
            if (jump_en || branch_taken) begin
                pend_q.delete();
                pend_q.push_back(jump_en ? jump_target : branch_target);
            end
        end
        #1 compare_model();
    endtask

    initial begin
        logic [31:0] t1, t2;
        #3 rst = 1'b1;
        #1;
        check("async_rst_pc", pc, RV);
        check("async_rst_fv", {31'd0, fetch_valid}, 32'd0);
        check("async_rst_trap", {31'd0, misalign_trap}, 32'd0);
        model_reset();
        tick();
        tick();
        @(negedge clk) rst = 1'b0;
        #1;
        check("rel_c1_pc", pc, 32'd0);
        check("rel_c1_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        check("rel_c2_fv", {31'd0, fetch_valid}, 32'd1);
        tick(); check("seq4", pc, 32'd4);
        tick(); check("seq8", pc, 32'd8);
        tick(); check("seq12", pc, 32'd12);

        drive(1, 100, 0, 0, 1, 0); tick();
        drive(0, 0, 1, 120, 1, 0); tick(); check("branch_fwd", pc, 32'd120);
        drive(1, 128, 0, 0, 1, 0); tick();
        drive(0, 0, 1, 120, 1, 0); tick(); check("branch_back", pc, 32'd120);

        drive(1, 200, 0, 0, 1, 0); tick();
        drive(0, 0, 1, 300, 0, 0); tick(); check("held_pc", pc, 32'd200);
        drive(0, 0, 0, 0, 1, 0);   tick(); check("pending_pc", pc, 32'd300);

        drive(1, 400, 1, 500, 1, 0); tick(); check("jump_prio", pc, 32'd400);

        drive(1, 32'hFFFF_FFFC, 0, 0, 1, 0); tick();
        check("wrap_plus4", pc_plus4, 32'd0);
        drive(0, 0, 0, 0, 1, 0); tick(); check("wrap_pc", pc, 32'd0);

        drive(1, 100, 0, 0, 1, 0); tick();
        drive(0, 0, 1, 102, 1, 0); tick();
`ifdef PROGRAM_COUNTER_TRAP_EN
        check("trap_pulse", {31'd0, misalign_trap}, 32'd1);
        check("trap_pc", pc, 32'h100);
        drive(0, 0, 0, 0, 1, 0); tick();
        check("trap_once", {31'd0, misalign_trap}, 32'd0);
        tick(); check("trap_next", pc, 32'h104);
`else
        check("mask_pc", pc, 32'd100);
`endif

        for (int i = 0; i < 2000; i++) begin
            t1 = $urandom; t2 = $urandom;
            if ($urandom % 8 != 0) t1[1:0] = 2'b00;
            if ($urandom % 8 != 0) t2[1:0] = 2'b00;
            if ($urandom % 32 == 0) t1 = 32'hFFFF_FFF8;
            drive($urandom % 7 == 0, t1, $urandom % 5 == 0, t2, $urandom % 4 != 0, $urandom % 4 == 0);
            tick();
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1;
                check("rand_rst_pc", pc, RV);
                check("rand_rst_fv", {31'd0, fetch_valid}, 32'd0);
                check("rand_rst_trap", {31'd0, misalign_trap}, 32'd0);
                model_reset();
                @(negedge clk) rst = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, is the redirect address for a misaligned target (PC_TRAP_EN only).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 stall  in  1  hold current pc; no advance.
REQ-006 branch_taken  in  1  conditional branch resolved taken this cycle.
REQ-007 branch_target  in  32  target from BranchTargetAdder (pc + imm_gn).
REQ-008 jump_en  in  1  JAL/JALR redirect this cycle.
REQ-009 jump_target  in  32  jump destination.
REQ-010 imem_ready  in  1  instruction memory accepts the fetch at pc this cycle.
REQ-011 pc  out  32  current fetch address.
REQ-012 pc_plus4  out  32  pc + 4, modulo 2^32, combinational from pc.
REQ-013 fetch_valid  out  1  pc holds a valid fetch request.
REQ-014 misalign_trap  out  1  one-cycle pulse on misaligned redirect; constant 0 without PC_TRAP_EN.

Function
REQ-015 FSM states SHALL be S_RESET, S_FETCH, S_TRAP; S_TRAP is unreachable without PC_TRAP_EN.
REQ-016 S_RESET: pc = RESET_VECTOR, fetch_valid = 0; unconditional transition to S_FETCH next edge.
REQ-017 S_FETCH: fetch_valid = 1; pc advances only when imem_ready = 1 and stall = 0 (an "advance").
REQ-018 Next-pc priority on advance: jump_en > branch_taken > pending redirect > pc_plus4.
REQ-019 A redirect (jump_en or branch_taken) asserted when no advance occurs SHALL be latched into a one-entry pending-redirect register with a valid bit.
REQ-020 A newer redirect overwrites a pending one; pending valid clears on the advance that consumes it.
REQ-021 Redirect latency: pc equals the selected target on the cycle after the advancing edge (one cycle).
REQ-022 Sequential wrap: pc = 32'hFFFF_FFFC advancing with no redirect yields pc = 32'h0000_0000.
REQ-023 stall and imem_ready = 0 are equivalent for holding; pc, pending register and state are unchanged apart from latching per REQ-019.
REQ-024 S_TRAP: pc = TRAP_VECTOR, fetch_valid = 0, misalign_trap = 1 for exactly one cycle; transition to S_FETCH next edge; pending redirect cleared.

Reset
REQ-025 rst asserted SHALL immediately (asynchronously) force state S_RESET, pc = RESET_VECTOR, fetch_valid = 0, misalign_trap = 0, pending valid = 0.
REQ-026 Reset mid-operation discards any pending redirect or trap in progress; first valid fetch is at RESET_VECTOR one cycle after rst deasserts.

Configuration
REQ-027 Macro PROGRAM_COUNTER_TRAP_EN defined: an advance whose selected target has bits [1:0] != 0 enters S_TRAP instead of loading the target.
REQ-028 Macro undefined: selected target loaded with bits [1:0] forced to 0; misalign_trap tied 0; no S_TRAP logic synthesised.

Structure
REQ-029 Shared package pc_pkg SHALL hold the state enum pc_state_t, the next-pc-select enum, and the constant PC_INCR = 4.
REQ-030 One sub-module, pc_next_sel, SHALL implement the combinational priority mux and alignment check; the FSM, pc register and pending register reside in program_counter.

Verification
REQ-031 Reset release, imem_ready = 1 -> cycle 1 pc = 0, fetch_valid = 0; cycle 2 fetch_valid = 1; subsequent pc 4, 8, 12.
REQ-032 pc = 100, branch_taken = 1, branch_target = 120 -> next pc = 120; pc = 128, branch_target = 120 (imm -8) -> next pc = 120.
REQ-033 pc = 200, imem_ready = 0, branch_taken = 1 target 300 for one cycle, then imem_ready = 1 -> pc holds 200, then 300.
REQ-034 Same cycle jump_en target 400 and branch_taken target 500 -> next pc = 400.
REQ-035 pc = 32'hFFFF_FFFC, no redirect -> next pc = 0, pc_plus4 = 0 while pc = 32'hFFFF_FFFC.
REQ-036 With PROGRAM_COUNTER_TRAP_EN, branch_target = 102 -> misalign_trap one cycle, pc = 32'h100, then 32'h104; without macro -> pc = 100.
